// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, frame width and the default bit period
// used by both the transmit and receive ends.
package uart_pkg;

    localparam int DEFAULT_BIT_CNT = 100000;
    localparam int DATA_BITS       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus falling-edge detect
// on the synchronised value.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rx_s,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic prev;

    // Presetting to the idle level keeps reset release from looking like a start edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rx_s = sync2;
    assign fall = prev & ~sync2;

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver: detects the start edge, samples each bit at its midpoint,
// and reports a good byte (valid pulse) or a bad stop bit (frame_err pulse).
module uart_recv
    import uart_pkg::*;
#(
    parameter int BIT_CNT = DEFAULT_BIT_CNT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int HALF_CNT = BIT_CNT / 2;
    localparam int CNT_W    = $clog2(BIT_CNT);

    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(BIT_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

    logic                 rx_s;
    logic                 fall;
    uart_state_t          state;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .rx_s (rx_s),
        .fall (fall)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // NOTE: state uses <= only; the pulse outputs default low here and are
            // raised below, so they last exactly one cycle without extra logic.
            valid     <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (fall) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == CNT_HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        if (rx_s) begin
                            // Line is back high at mid-start: treat as a glitch.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (rx_s) begin
                            data  <= shift;
                            valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv at BIT_CNT=16: good frames, back-to-back frames,
// framing error, glitch rejection, mid-frame reset and bit-period tolerance.
`timescale 1ns/100ps
module tb_uart_recv;

    localparam int    BIT_CNT = 16;
    localparam real   CLK_NS  = 10.0;
    localparam real   BIT_NS  = BIT_CNT * CLK_NS;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int valid_cnt   = 0;
    int ferr_cnt    = 0;
    int overlap_cnt = 0;
    int busy_bad    = 0;
    int busy_rise   = 0;
    logic prev_busy = 1'b0;
    logic [7:0] rx_q[$];

    uart_recv #(.BIT_CNT(BIT_CNT)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #(CLK_NS / 2) clk = ~clk;

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (valid) begin
            valid_cnt++;
            rx_q.push_back(data);
            if (busy || !prev_busy) busy_bad++;
        end
        if (frame_err) ferr_cnt++;
        if (valid && frame_err) overlap_cnt++;
        if (busy && !prev_busy) busy_rise++;
        prev_busy = busy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start bit, 8 data bits LSB first, then one stop-bit period at stop_val.
    // The line is left at stop_val; the caller releases it.
    task automatic send_frame(input logic [7:0] b, input real bit_ns, input logic stop_val);
        din = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            din = b[i];
            #(bit_ns);
        end
        din = stop_val;
        #(bit_ns);
    endtask

    task automatic align();
        @(posedge clk);
        #3;
    endtask

    function automatic logic [31:0] rx_at(input int idx);
        if (rx_q.size() > idx) return {24'h0, rx_q[idx]};
        return 32'hDEAD;
    endfunction

    int v0, f0, r0, n0;

    initial begin
        // Reset
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_data", data, 8'h00);
        check("reset_valid", valid, 1'b0);
        check("reset_ferr", frame_err, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b1;
        repeat (5) @(posedge clk);

        // Glitch: three cycles low, rejected at the half-bit sample
        v0 = valid_cnt; f0 = ferr_cnt; r0 = busy_rise;
        align();
        din = 1'b0;
        repeat (3) @(posedge clk);
        #3 din = 1'b1;
        repeat (3 * BIT_CNT) @(negedge clk);
        check("glitch_busy_pulse", busy_rise - r0, 1);
        check("glitch_valid", valid_cnt - v0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_busy_end", busy, 1'b0);

        // Framing error with the line then held low for two more bits
        v0 = valid_cnt; f0 = ferr_cnt;
        align();
        send_frame(8'h0F, BIT_NS, 1'b0);
        r0 = busy_rise;
        #(2 * BIT_NS);
        check("held_low_no_start", busy_rise - r0, 0);
        check("ferr_count", ferr_cnt - f0, 1);
        check("ferr_no_valid", valid_cnt - v0, 0);
        check("ferr_data_kept", data, 8'h00);
        din = 1'b1;
        repeat (2 * BIT_CNT) @(negedge clk);
        check("ferr_idle_busy", busy, 1'b0);

        // Single good byte
        v0 = valid_cnt; f0 = ferr_cnt; n0 = rx_q.size();
        align();
        send_frame(8'h55, BIT_NS, 1'b1);
        repeat (2 * BIT_CNT) @(negedge clk);
        check("single_valid", valid_cnt - v0, 1);
        check("single_byte", rx_at(n0), 8'h55);
        check("single_data", data, 8'h55);
        check("single_ferr", ferr_cnt - f0, 0);
        check("busy_with_valid", busy_bad, 0);

        // Back-to-back frames with no idle gap
        v0 = valid_cnt; f0 = ferr_cnt; n0 = rx_q.size();
        align();
        send_frame(8'hA3, BIT_NS, 1'b1);
        send_frame(8'h3C, BIT_NS, 1'b1);
        repeat (2 * BIT_CNT) @(negedge clk);
        check("b2b_valid", valid_cnt - v0, 2);
        check("b2b_first", rx_at(n0), 8'hA3);
        check("b2b_second", rx_at(n0 + 1), 8'h3C);
        check("b2b_ferr", ferr_cnt - f0, 0);

        // Transmitter about 3% fast, then about 3% slow
        v0 = valid_cnt; n0 = rx_q.size();
        align();
        send_frame(8'h96, 15.5 * CLK_NS, 1'b1);
        repeat (2 * BIT_CNT) @(negedge clk);
        align();
        send_frame(8'h96, 16.5 * CLK_NS, 1'b1);
        repeat (2 * BIT_CNT) @(negedge clk);
        check("tol_valid", valid_cnt - v0, 2);
        check("tol_fast", rx_at(n0), 8'h96);
        check("tol_slow", rx_at(n0 + 1), 8'h96);

        // Reset during data bit 4 of 0xFF
        v0 = valid_cnt; f0 = ferr_cnt;
        align();
        fork
            send_frame(8'hFF, BIT_NS, 1'b1);
            begin
                repeat (5 * BIT_CNT + BIT_CNT / 2) @(negedge clk);
                check("pre_reset_busy", busy, 1'b1);
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                check("midrst_busy", busy, 1'b0);
                check("midrst_data", data, 8'h00);
            end
        join
        repeat (2 * BIT_CNT) @(negedge clk);
        check("midrst_no_valid", valid_cnt - v0, 0);
        check("midrst_no_ferr", ferr_cnt - f0, 0);

        n0 = rx_q.size();
        align();
        send_frame(8'h81, BIT_NS, 1'b1);
        repeat (2 * BIT_CNT) @(negedge clk);
        check("post_rst_valid", valid_cnt - v0, 1);
        check("post_rst_byte", rx_at(n0), 8'h81);
        check("valid_ferr_overlap", overlap_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
